mul_result_buffer: RTL
======================

MUL_RESULT_BUFFER -- requirements
Module: mul_result_buffer

Interface
REQ-001 Parameter DEPTH, default 4, result FIFO entries; power of two, 2..16.
REQ-002 Parameter LAT, default 2, multiplier register stages between operand presentation and valid res.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 issue_valid  in  1  operands are on the multiplier data1/data2 inputs this cycle.
REQ-006 issue_ready  out  1  buffer can accept an issue this cycle.
REQ-007 issue_tag  in  5  destination tag travelling with the operation; present only with MUL_RB_TAG_EN.
REQ-008 mul_res  in  64  multiplier res output, combinational from its final compression/CLA stage.
REQ-009 out_valid  out  1  head FIFO entry is valid.
REQ-010 out_ready  in  1  consumer accepts head entry.
REQ-011 out_res  out  64  head entry product.
REQ-012 out_tag  out  5  head entry tag; present only with MUL_RB_TAG_EN.
REQ-013 occupancy  out  5  number of valid FIFO entries (0..DEPTH).

Function
REQ-014 Accept = issue_valid & issue_ready; an accept in cycle T SHALL produce a capture of mul_res at the rising edge ending cycle T+LAT.
REQ-015 Operation validity SHALL be tracked by a LAT-deep valid shift register (and parallel tag shift register) advancing every cycle; the multiplier never stalls.
REQ-016 issue_ready SHALL be (occupancy + in-flight count) < DEPTH, in-flight = ones in valid shift register; no combinational dependence on out_ready.
REQ-017 Capture SHALL write mul_res (and tag) at the tail pointer and increment tail modulo DEPTH.
REQ-018 Pop = out_valid & out_ready; head pointer increments modulo DEPTH.
REQ-019 Simultaneous capture and pop SHALL leave occupancy unchanged; both pointers advance.
REQ-020 No bypass: capture into an empty FIFO SHALL raise out_valid in the following cycle; minimum issue-to-out_valid latency LAT+1 cycles.
REQ-021 out_valid SHALL equal (occupancy != 0); out_res and out_tag SHALL be driven to 0 whenever out_valid is 0.
REQ-022 Results SHALL leave in issue order; out_valid/out_res SHALL hold stable while out_valid & !out_ready.
REQ-023 Credit rule (REQ-016) SHALL guarantee capture never occurs with occupancy DEPTH and no pop.
REQ-024 occupancy arithmetic SHALL be 5 bits unsigned; no wrap beyond DEPTH.

Reset
REQ-025 On rst: valid shift register, pointers, occupancy cleared; out_valid 0, out_res 0, out_tag 0, issue_ready 1 the cycle after.
REQ-026 FIFO storage array SHALL NOT require reset.
REQ-027 Reset mid-operation SHALL discard all in-flight operations; stale multiplier results arriving after reset SHALL NOT be captured.

Configuration
REQ-028 Macro MUL_RB_TAG_EN: defined -> issue_tag/out_tag ports, tag shift register and tag storage present; undefined -> those ports and storage absent, all other behaviour identical.

Verification
REQ-029 Issue data1=3, data2=-5 at T, out_ready=1 -> out_valid in T+3, out_res=0xFFFFFFFFFFFFFFF1, single cycle.
REQ-030 out_ready=0, issue_valid=1 held: exactly 4 accepts, issue_ready low from 5th cycle, occupancy reaches 4, out_valid holds first product.
REQ-031 out_ready=1, issue every cycle for 20 cycles (a=i, b=i+1) -> 20 products in order, pointers wrap, throughput 1/cycle after fill.
REQ-032 Issue 2 ops, assert rst at T+1 for one cycle -> no out_valid ever; occupancy 0; next issue returns its correct product.
REQ-033 With MUL_RB_TAG_EN: tags 5,17,31 with data1=-2^31, data2=-2^31 etc. -> out_tag 5,17,31 in order, first out_res=0x4000000000000000.

Source files
------------

// File: rtl/mul_result_buffer.sv
// Result buffer behind a fixed-latency, non-stalling multiplier: tracks in-flight
// operations, captures products into a FIFO and grants issue credits. Optional tags: MUL_RB_TAG_EN.
module mul_result_buffer #(
  parameter int DEPTH = 4,
  parameter int LAT   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        issue_valid,
  output logic        issue_ready,
`ifdef MUL_RB_TAG_EN
  input  logic [4:0]  issue_tag,
  output logic [4:0]  out_tag,
`endif
  input  logic [63:0] mul_res,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_res,
  output logic [4:0]  occupancy
);

  // Handshakes: a transfer happens on a rising edge where valid & ready are both 1;
  // ready never depends combinationally on the matching valid or on out_ready.

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [LAT-1:0] vsr;
  logic [LAT:0]   vsr_ext;
  logic [4:0]     inflight;
  logic [PW-1:0]  head;
  logic [PW-1:0]  tail;
  logic [63:0]    mem [DEPTH];
  logic           accept;
  logic           capture;
  logic           pop;

  assign accept  = issue_valid & issue_ready;
  assign capture = vsr[LAT-1];
  assign pop     = out_valid & out_ready;
  assign vsr_ext = {vsr, accept};

  always_comb begin
    inflight = '0;
    for (int i = 0; i < LAT; i++) inflight = inflight + 5'(vsr[i]);
  end

  // Credits cover both stored results and products still inside the multiplier,
  // so a capture always finds a free slot.
  assign issue_ready = ({1'b0, occupancy} + {1'b0, inflight}) < 6'(DEPTH);
  assign out_valid   = (occupancy != 5'd0);
  assign out_res     = out_valid ? mem[head] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      vsr       <= '0;
      head      <= '0;
      tail      <= '0;
      occupancy <= '0;
    end else begin
      vsr <= vsr_ext[LAT-1:0];
      if (capture) tail <= tail + 1'b1;
      if (pop) head <= head + 1'b1;
      if (capture && !pop) occupancy <= occupancy + 5'd1;
      else if (pop && !capture) occupancy <= occupancy - 5'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (capture) mem[tail] <= mul_res;
  end

`ifdef MUL_RB_TAG_EN
  logic [4:0] tag_sr  [LAT];
  logic [4:0] tag_mem [DEPTH];

  always_ff @(posedge clk) begin
    tag_sr[0] <= issue_tag;
    for (int i = 1; i < LAT; i++) tag_sr[i] <= tag_sr[i-1];
    if (capture) tag_mem[tail] <= tag_sr[LAT-1];
  end

  assign out_tag = out_valid ? tag_mem[head] : '0;
`endif

endmodule
